// File: rtl/hps_pkg.sv
// hps_pkg: shared FSM encoding, harmonic index sizing and saturation helper for the HPS engine
package hps_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  function automatic int harmonic_idx_width(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic logic [127:0] sat_to(input logic [127:0] v, input int unsigned w);
    logic [127:0] lim;
    lim = (128'd1 << w) - 128'd1;
    return v > lim ? lim : v;
  endfunction
endpackage

// File: rtl/hps_quotient_counter.sv
// hps_quotient_counter: tracks floor(k/DIVISOR) as k steps by one, using a mod-DIVISOR prescaler
module hps_quotient_counter #(
  parameter int K_WIDTH = 12,
  parameter int DIVISOR = 1,
  parameter int K_START = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               inc,
  output logic [K_WIDTH-1:0] quotient
);
  localparam int RW = $clog2(DIVISOR) + 1;
  logic [RW-1:0] rem;
  logic wrap;
  assign wrap = rem == RW'(DIVISOR - 1);
  always_ff @(posedge clock)
    if (!reset_n) begin
      quotient <= '0;
      rem <= '0;
    end else if (load) begin
      quotient <= K_WIDTH'(K_START / DIVISOR);
      rem <= RW'(K_START % DIVISOR);
    end else if (inc) begin
      quotient <= wrap ? quotient + K_WIDTH'(1) : quotient;
      rem <= wrap ? '0 : rem + RW'(1);
    end
endmodule

// File: rtl/harmonic_product_sequencer.sv
// harmonic_product_sequencer: scans bins, multiplies |X[k/h]| for h=1..H, streams products, tracks the peak
module harmonic_product_sequencer import hps_pkg::*; #(
  parameter int K_WIDTH       = 12,
  parameter int MAG_WIDTH     = 34,
  parameter int PROD_WIDTH    = 34,
  parameter int NUM_HARMONICS = 3,
  parameter int PROD_SHIFT    = 17,
  parameter int READ_LATENCY  = 1,
  parameter int K_START       = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fft_last,
  input  logic [K_WIDTH-1:0]    k_limit,
  output logic [K_WIDTH-1:0]    ram_addr,
  output logic                  ram_enable,
  input  logic [MAG_WIDTH-1:0]  ram_rdata,
  output logic                  hps_valid,
  output logic [K_WIDTH-1:0]    hps_k,
  output logic [PROD_WIDTH-1:0] hps_value,
  output logic [K_WIDTH-1:0]    peak_k,
  output logic [PROD_WIDTH-1:0] peak_value,
  output logic                  done,
  output logic                  busy,
  output logic                  overrun
);
  localparam int HW = harmonic_idx_width(NUM_HARMONICS);
  localparam int TW = K_WIDTH + HW + 1;
  localparam int PW = PROD_WIDTH + MAG_WIDTH;
  state_t state, state_n;
  logic [K_WIDTH-1:0] k, k_lim, run_k, rk;
  logic [HW-1:0] h, rh;
  logic [K_WIDTH-1:0] quot [NUM_HARMONICS];
  logic [READ_LATENCY-1:0] tv;
  logic [READ_LATENCY-1:0][TW-1:0] tag;
  logic [PROD_WIDTH-1:0] acc, run_v, prod;
  logic [PW-1:0] mult;
  logic empty, h_last, last_read, load, inc, rv, rlast, r_final, upd;
  for (genvar i = 0; i < NUM_HARMONICS; i++) begin : g_q
    hps_quotient_counter #(.K_WIDTH(K_WIDTH), .DIVISOR(i + 1), .K_START(K_START)) u_q (
      .clock(clock), .reset_n(reset_n), .load(load), .inc(inc), .quotient(quot[i]));
  end
  assign empty = k_lim < K_WIDTH'(K_START);
  assign h_last = h == HW'(NUM_HARMONICS - 1);
  assign last_read = ram_enable && h_last && k == k_lim;
  assign load = state == IDLE && fft_last;
  assign inc = ram_enable && h_last && !last_read;
  // return-path tag travels alongside the RAM latency
  assign rv = tv[READ_LATENCY-1];
  assign {rk, rh, rlast} = tag[READ_LATENCY-1];
  assign r_final = rv && rh == HW'(NUM_HARMONICS - 1);
  assign mult = (PW'(acc) * PW'(ram_rdata)) >> PROD_SHIFT;
  assign prod = PROD_WIDTH'(sat_to(128'(rh == '0 ? PW'(ram_rdata) : mult), PROD_WIDTH));
  assign upd = r_final && prod > run_v;
  always_ff @(posedge clock) state <= !reset_n ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE  ? (fft_last ? SCAN : IDLE)
            : state == SCAN  ? (empty ? DONE : last_read ? DRAIN : SCAN)
            : state == DRAIN ? (rv && rlast ? DONE : DRAIN)
            : IDLE;
  end
  always_comb begin
    ram_enable = state == SCAN && !empty;
    busy = state != IDLE;
    done = state == DONE;
    overrun = fft_last && busy;
    ram_addr = ram_enable ? quot[h] : '0;
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      k <= '0;
      k_lim <= '0;
      h <= '0;
      tv <= '0;
      tag <= '0;
      acc <= '0;
      run_k <= '0;
      run_v <= '0;
      hps_valid <= 1'b0;
      hps_k <= '0;
      hps_value <= '0;
      peak_k <= '0;
      peak_value <= '0;
    end else begin
      if (load) begin
        k_lim <= k_limit;
        k <= K_WIDTH'(K_START);
        h <= '0;
      end else if (ram_enable) begin
        h <= h_last ? '0 : h + HW'(1);
        k <= inc ? k + K_WIDTH'(1) : k;
      end
      tv[0] <= ram_enable;
      tag[0] <= {k, h, last_read};
      for (int i = 1; i < READ_LATENCY; i++) begin
        tv[i] <= tv[i-1];
        tag[i] <= tag[i-1];
      end
      if (rv) acc <= prod;
      hps_valid <= r_final;
      if (r_final) begin
        hps_k <= rk;
        hps_value <= prod;
      end
      if (load) begin
        run_k <= '0;
        run_v <= '0;
      end else if (upd) begin
        run_k <= rk;
        run_v <= prod;
      end
      if (state_n == DONE) begin
        peak_k <= upd ? rk : run_k;
        peak_value <= upd ? prod : run_v;
      end
    end
endmodule

// File: tb/tb_harmonic_product_sequencer.sv
// tb_harmonic_product_sequencer: two engines (shift 0 / latency 1, shift 17 / latency 4) against an arithmetic model
module tb_harmonic_product_sequencer;
  localparam int H = 3;
  localparam int KS = 1;
  localparam logic [127:0] MAX = (128'd1 << 34) - 128'd1;
  typedef struct packed {logic [11:0] k; logic [33:0] v; int c;} pr_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] fl = '0;
  logic [11:0] k_limit = '0;
  logic [33:0] mem [4096];
  logic [33:0] rd0, rd1;
  logic [33:0] p1 [4];
  logic en [2];
  logic hv [2];
  logic dn [2];
  logic bz [2];
  logic ov [2];
  logic [11:0] addr [2];
  logic [11:0] hk [2];
  logic [11:0] pk [2];
  logic [33:0] hval [2];
  logic [33:0] pval [2];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int dcnt [2] = '{0, 0};
  int ocnt [2] = '{0, 0};
  int dcyc [2];
  logic [11:0] dpk [2];
  logic [33:0] dpv [2];
  pr_t q0[$];
  pr_t q1[$];
  logic [11:0] a0[$];
  int st, b0, b1, ab;

  harmonic_product_sequencer #(.PROD_SHIFT(0), .READ_LATENCY(1)) u0 (
    .clock(clock), .reset_n(reset_n), .fft_last(fl[0]), .k_limit(k_limit),
    .ram_addr(addr[0]), .ram_enable(en[0]), .ram_rdata(rd0),
    .hps_valid(hv[0]), .hps_k(hk[0]), .hps_value(hval[0]),
    .peak_k(pk[0]), .peak_value(pval[0]), .done(dn[0]), .busy(bz[0]), .overrun(ov[0]));
  harmonic_product_sequencer #(.PROD_SHIFT(17), .READ_LATENCY(4)) u1 (
    .clock(clock), .reset_n(reset_n), .fft_last(fl[1]), .k_limit(k_limit),
    .ram_addr(addr[1]), .ram_enable(en[1]), .ram_rdata(rd1),
    .hps_valid(hv[1]), .hps_k(hk[1]), .hps_value(hval[1]),
    .peak_k(pk[1]), .peak_value(pval[1]), .done(dn[1]), .busy(bz[1]), .overrun(ov[1]));

  always #5 clock = ~clock;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    rd0 <= mem[addr[0]];
    p1[0] <= mem[addr[1]];
    for (int i = 1; i < 4; i++) p1[i] <= p1[i-1];
  end
  assign rd1 = p1[3];

  always @(negedge clock) begin
    if (hv[0]) q0.push_back(pr_t'{hk[0], hval[0], cyc});
    if (hv[1]) q1.push_back(pr_t'{hk[1], hval[1], cyc});
    if (en[0]) a0.push_back(addr[0]);
    for (int i = 0; i < 2; i++) begin
      if (dn[i]) begin
        dcnt[i] <= dcnt[i] + 1;
        dcyc[i] <= cyc;
        dpk[i] <= pk[i];
        dpv[i] <= pval[i];
      end
      if (ov[i]) ocnt[i] <= ocnt[i] + 1;
    end
  end

  function automatic logic [127:0] sat(input logic [127:0] v);
    return v > MAX ? MAX : v;
  endfunction

  function automatic logic [127:0] model(input int k, input int s);
    logic [127:0] p;
    p = sat(128'(mem[k]));
    for (int h = 2; h <= H; h++) p = sat((p * 128'(mem[k / h])) >> s);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 4096; i++)
      mem[i] = mode == 0 ? 34'(i + 1) : mode == 1 ? 34'h2_0000_0000 :
               mode == 2 ? 34'($urandom_range(0, 300)) :
               mode == 3 ? 34'({$urandom, $urandom}) : 34'($urandom_range(0, 1 << 20));
  endtask

  task automatic start(input int klim);
    b0 = q0.size();
    b1 = q1.size();
    ab = a0.size();
    k_limit = 12'(klim);
    fl = 2'b11;
    st = cyc;
    tick(1);
    fl = '0;
    k_limit = 12'($urandom);
  endtask

  task automatic wait_done(input int n0, input int n1, input int lim);
    int t;
    t = 0;
    while ((dcnt[0] < n0 || dcnt[1] < n1) && t < lim) begin
      tick(1);
      t++;
    end
    chk("done_reached", dcnt[0] >= n0 && dcnt[1] >= n1, 1);
  endtask

  task automatic zero_check(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ctl%0d", tag, i), {en[i], hv[i], dn[i], bz[i], ov[i]}, 0);
      chk($sformatf("%s_bins%0d", tag, i), {addr[i], hk[i], pk[i]}, 0);
      chk($sformatf("%s_vals%0d", tag, i), {hval[i], pval[i]}, 0);
    end
  endtask

  task automatic check_scan(input int klim, input string tag);
    logic [127:0] x0, x1, m0, m1;
    int e0, e1, ea, k0, k1, n, kk;
    n = klim >= KS ? klim - KS + 1 : 0;
    chk({tag, "_cnt0"}, q0.size() - b0, n);
    chk({tag, "_cnt1"}, q1.size() - b1, n);
    chk({tag, "_reads"}, a0.size() - ab, n * H);
    e0 = 0; e1 = 0; ea = 0; m0 = 0; m1 = 0; k0 = 0; k1 = 0;
    for (int j = 0; j < n; j++) begin
      kk = KS + j;
      x0 = model(kk, 0);
      x1 = model(kk, 17);
      if (b0 + j >= q0.size() || q0[b0+j].k != 12'(kk) || 128'(q0[b0+j].v) != x0) e0++;
      if (b1 + j >= q1.size() || q1[b1+j].k != 12'(kk) || 128'(q1[b1+j].v) != x1) e1++;
      for (int h = 1; h <= H; h++)
        if (ab + j * H + h - 1 >= a0.size() || a0[ab + j * H + h - 1] != 12'(kk / h)) ea++;
      if (x0 > m0) begin m0 = x0; k0 = kk; end
      if (x1 > m1) begin m1 = x1; k1 = kk; end
    end
    chk({tag, "_stream0_errs"}, e0, 0);
    chk({tag, "_stream1_errs"}, e1, 0);
    chk({tag, "_addr_errs"}, ea, 0);
    chk({tag, "_peak_k0"}, dpk[0], k0);
    chk({tag, "_peak_v0"}, dpv[0], m0);
    chk({tag, "_peak_k1"}, dpk[1], k1);
    chk({tag, "_peak_v1"}, dpv[1], m1);
  endtask

  task automatic run(input int klim, input string tag);
    int d0, d1;
    d0 = dcnt[0] + 1;
    d1 = dcnt[1] + 1;
    start(klim);
    wait_done(d0, d1, 20000);
    check_scan(klim, tag);
  endtask

  initial begin
    int t, d0, d1, o0, o1;
    tick(3);
    zero_check("reset");
    reset_n = 1'b1;
    tick(2);

    fill(0);
    run(7, "ramp");
    chk("ramp_k6", q0[b0+5].v, 84);
    chk("ramp_lat0", q0[b0].c - (st + 1), H + 1);
    chk("ramp_lat1", q1[b1].c - (st + 1), H + 4);
    chk("ramp_shift", q1[b1].c - q0[b0].c, 3);
    chk("ramp_done_last0", dcyc[0], q0[q0.size()-1].c);
    chk("ramp_done_last1", dcyc[1], q1[q1.size()-1].c);
    chk("ramp_idle", {bz[0], bz[1]}, 0);

    fill(1);
    run(10, "sat");
    chk("sat_pk0", dpk[0], KS);
    chk("sat_pv1", dpv[1], MAX);

    fill(2);
    o0 = ocnt[0];
    o1 = ocnt[1];
    d0 = dcnt[0] + 1;
    d1 = dcnt[1] + 1;
    start(20);
    tick(10);
    fl = 2'b11;
    tick(1);
    fl = '0;
    t = 0;
    while (!dn[0] && t < 500) begin
      tick(1);
      t++;
    end
    fl[0] = 1'b1;
    tick(1);
    fl = '0;
    wait_done(d0, d1, 2000);
    check_scan(20, "ovr");
    tick(3);
    chk("ovr_cnt0", ocnt[0] - o0, 2);
    chk("ovr_cnt1", ocnt[1] - o1, 1);
    chk("ovr_norestart", bz[0], 0);
    chk("ovr_single_done", dcnt[0], d0);

    fill(2);
    d0 = dcnt[0];
    d1 = dcnt[1];
    start(30);
    t = 0;
    while (!(en[0] && addr[0] == 12'd4) && t < 200) begin
      tick(1);
      t++;
    end
    reset_n = 1'b0;
    tick(1);
    zero_check("abort");
    reset_n = 1'b1;
    tick(6);
    chk("abort_nodone", {dcnt[0] - d0, dcnt[1] - d1}, 0);
    fill(3);
    run(25, "post_abort");

    run(0, "empty");
    chk("empty_done0", dcyc[0] - st, 2);
    chk("empty_done1", dcyc[1] - st, 2);

    for (int r = 0; r < 4; r++) begin
      fill(2 + r % 3);
      run($urandom_range(0, 40), $sformatf("rnd%0d", r));
    end

    fill(4);
    run(4095, "full");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
